// File: rtl/mux_select_arbiter_pkg.sv
// Shared constants and FSM encoding for the 32-way round-robin select arbiter.
// The code 2'd3 is never entered; the FSM treats it as IDLE.
package mux_select_arbiter_pkg;

   localparam int N_REQ        = 32;
   localparam int SEL_W        = 5;
   localparam int MAX_HOLD_DEF = 16;
   localparam int HOLD_W       = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mux_select_arbiter_rr_pick.sv
// Round-robin winner search: rotate the request vector by ptr, take the lowest
// set bit, then add ptr back (mod 32) to recover the absolute requester index.
module rr_pick_32
   import mux_select_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[SEL_W'(i) + ptr];
      end
   end

   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign found = |req;
   assign idx   = off + ptr;

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin owner arbiter for a shared 32:1 select tree with a one-cycle gap
// between owners. "release" is a reserved word, so the release strobe is "rel".
module mux_select_arbiter
   import mux_select_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             rel,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LIM =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic TMO_EN = (MAX_HOLD != 0);

   arb_state_t        state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              tmo_q, tmo_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic              found;
   logic [SEL_W-1:0]  win;
   logic              req_drop, hold_hit;

   rr_pick_32 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (found),
      .idx   (win)
   );

   assign req_drop = ~req[sel_q];
   assign hold_hit = TMO_EN && (hold_q == HOLD_LIM);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      tmo_d   = 1'b0;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = win;
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
               busy_d  = 1'b1;
               hold_d  = '0;
               state_d = OWN;
            end
         end
         OWN: begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
            if (rel || req_drop || hold_hit) begin
               grant_d = '0;
               busy_d  = 1'b0;
               ptr_d   = sel_q + 1'b1;
               tmo_d   = hold_hit && !rel && !req_drop;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign sel     = sel_q;
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign timeout = tmo_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: two instances (MAX_HOLD 16 and 0) checked every
// cycle against a tenure-level model, plus directed literal expectations.
module tb_mux_select_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] req   = '0;
   logic        rel   = 1'b0;

   logic [4:0]  sel_a,   sel_b;
   logic [31:0] grant_a, grant_b;
   logic        busy_a,  busy_b;
   logic        tmo_a,   tmo_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mux_select_arbiter #(.MAX_HOLD(16)) dut (
      .clock(clock), .reset(reset), .req(req), .rel(rel),
      .sel(sel_a), .grant(grant_a), .busy(busy_a), .timeout(tmo_a)
   );

   mux_select_arbiter #(.MAX_HOLD(0)) dut0 (
      .clock(clock), .reset(reset), .req(req), .rel(rel),
      .sel(sel_b), .grant(grant_b), .busy(busy_b), .timeout(tmo_b)
   );

   always #5 clock = ~clock;

   // Model: who owns the resource, for how many cycles so far, and where the scan resumes.
   typedef struct {
      int owner;
      int held;
      bit gap;
      int ptr;
      int sel;
      bit tmo;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t step(mstate_t s, logic [31:0] r, logic rl, logic rst, int mh);
      mstate_t n;
      bit drop, limit;
      n = s;
      n.tmo = 1'b0;
      if (rst) begin
         n.owner = -1; n.held = 0; n.gap = 1'b0; n.ptr = 0; n.sel = 0;
         return n;
      end
      if (s.owner >= 0) begin
         drop  = !r[s.owner];
         limit = (mh != 0) && (s.held + 1 >= mh);
         if (rl || drop || limit) begin
            n.owner = -1;
            n.gap   = 1'b1;
            n.ptr   = (s.owner + 1) % 32;
            n.tmo   = limit && !rl && !drop;
         end else begin
            n.held = s.held + 1;
         end
      end else if (s.gap) begin
         n.gap = 1'b0;
      end else begin
         for (int k = 0; k < 32; k++) begin
            if (r[(s.ptr + k) % 32]) begin
               n.owner = (s.ptr + k) % 32;
               n.sel   = n.owner;
               n.held  = 0;
               break;
            end
         end
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      ma = '{owner: -1, held: 0, gap: 1'b0, ptr: 0, sel: 0, tmo: 1'b0};
      mb = ma;
   end

   always @(posedge clock) begin
      ma <= step(ma, req, rel, reset, 16);
      mb <= step(mb, req, rel, reset, 0);
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("model16_sel",   {27'd0, sel_a}, 32'(ma.sel));
         check("model16_grant", grant_a, (ma.owner >= 0) ? (32'd1 << ma.owner) : 32'd0);
         check("model16_busy",  {31'd0, busy_a}, {31'd0, ma.owner >= 0});
         check("model16_tmo",   {31'd0, tmo_a}, {31'd0, ma.tmo});
         check("model0_sel",    {27'd0, sel_b}, 32'(mb.sel));
         check("model0_grant",  grant_b, (mb.owner >= 0) ? (32'd1 << mb.owner) : 32'd0);
         check("model0_busy",   {31'd0, busy_b}, {31'd0, mb.owner >= 0});
         check("model0_tmo",    {31'd0, tmo_b}, {31'd0, mb.tmo});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle2();
      req = '0; rel = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      int cnt;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_grant", grant_a, 32'h0);
      check("reset_sel",   {27'd0, sel_a}, 32'd0);
      check("reset_busy",  {31'd0, busy_a}, 32'd0);
      reset = 1'b0;

      // Single requester, then drop
      req = 32'h1 << 5;
      tick();
      check("single_sel",   {27'd0, sel_a}, 32'd5);
      check("single_grant", grant_a, 32'h0000_0020);
      check("single_busy",  {31'd0, busy_a}, 32'd1);
      req = '0;
      tick();
      check("drop_grant", grant_a, 32'h0);
      check("drop_sel_held", {27'd0, sel_a}, 32'd5);
      tick();
      req = (32'h1 << 5) | (32'h1 << 7);
      tick();
      check("ptr6_pick", {27'd0, sel_a}, 32'd7);
      idle2();

      // All requesting, release on second OWN cycle: 0..31 then 0
      reset = 1'b1; tick(); reset = 1'b0;
      req = '1;
      tick();
      for (int k = 0; k <= 32; k++) begin
         check("rr_order", {27'd0, sel_a}, 32'(k % 32));
         check("rr_busy",  {31'd0, busy_a}, 32'd1);
         tick();
         rel = 1'b1;
         tick();
         rel = 1'b0;
         check("rr_gap", grant_a, 32'h0);
         tick();
         tick();
      end
      idle2();

      // Wrap: ptr=4 after serving 3, then 30 before 3; serving 31 sets ptr=0
      reset = 1'b1; tick(); reset = 1'b0;
      req = 32'h1 << 3;
      tick();
      idle2();
      req = (32'h1 << 3) | (32'h1 << 30);
      tick();
      check("wrap_first", {27'd0, sel_a}, 32'd30);
      rel = 1'b1; tick(); rel = 1'b0;
      tick(); tick();
      check("wrap_second", {27'd0, sel_a}, 32'd3);
      idle2();
      req = 32'h1 << 31;
      tick();
      check("serve31", {27'd0, sel_a}, 32'd31);
      idle2();
      req = 32'h1 | (32'h1 << 20);
      tick();
      check("ptr_wrap0", {27'd0, sel_a}, 32'd0);
      idle2();

      // Timeout after 16 cycles; MAX_HOLD=0 instance keeps holding
      req = 32'h1 << 7;
      tick();
      cnt = 0;
      while (busy_a && cnt < 40) begin
         cnt++;
         tick();
      end
      check("tenure_len", 32'(cnt), 32'd16);
      check("timeout_pulse", {31'd0, tmo_a}, 32'd1);
      check("timeout_gap_grant", grant_a, 32'h0);
      tick();
      check("timeout_clear", {31'd0, tmo_a}, 32'd0);
      repeat (24) tick();
      check("nohold_grant", grant_b, 32'h0000_0080);
      check("nohold_busy",  {31'd0, busy_b}, 32'd1);
      idle2();

      // Reset on the third OWN cycle of owner 12
      req = 32'h1 << 12;
      tick(); tick(); tick();
      check("own12_busy", {31'd0, busy_a}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_own_grant", grant_a, 32'h0);
      check("rst_own_sel",   {27'd0, sel_a}, 32'd0);
      check("rst_own_busy",  {31'd0, busy_a}, 32'd0);
      check("rst_own_tmo",   {31'd0, tmo_a}, 32'd0);
      req = (32'h1 << 1) | (32'h1 << 12);
      tick();
      check("rst_ptr0", {27'd0, sel_a}, 32'd1);
      idle2();

      // Release coincides with the hold limit
      req = 32'h1 << 9;
      tick();
      repeat (15) tick();
      check("coincide_busy", {31'd0, busy_a}, 32'd1);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check("coincide_exit", {31'd0, busy_a}, 32'd0);
      check("coincide_tmo",  {31'd0, tmo_a}, 32'd0);
      idle2();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
